// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer chain: FSM states, BCD limits
// and the BCD clamp/convert helpers (also used by the score display path).
package timer_pkg;

   localparam int         CNT_W_DEF = 7;
   localparam logic [3:0] BCD_MAX   = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSED,
      ST_EXPIRED
   } state_t;

   // Out-of-range nibbles (A..F) saturate to 9 rather than wrapping.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

   function automatic logic [CNT_W_DEF-1:0] bcd_to_bin(input logic [3:0] tens,
                                                      input logic [3:0] ones);
      return CNT_W_DEF'(bcd_clamp(tens)) * CNT_W_DEF'(10) + CNT_W_DEF'(bcd_clamp(ones));
   endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Seconds prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the last
// one. clr wins over en; with en low the count holds (used for pause).
module timer_prescaler #(
   parameter int TICK_DIV = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int            PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   // Free-running divider, wraps to 0 on the tick cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en)  cnt <= tick ? '0 : cnt + 1'b1;
   end

endmodule

// File: rtl/timer_tick_ctrl.sv
// Countdown control for the two-digit BCD display: load/decrement strobes to
// the digit cells, binary shadow of the remaining seconds, timeout pulse and
// start/pause/abort sequencing. Build macro TIMER_WARN_EN adds the low-time
// warn flag; without it warn is tied low.
module timer_tick_ctrl
   import timer_pkg::*;
#(
   parameter int TICK_DIV  = 50000000,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int WARN_SECS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             abort,
   input  logic [3:0]       preset_tens,
   input  logic [3:0]       preset_ones,
   output logic             dig_load,
   output logic [3:0]       dig_tens_val,
   output logic [3:0]       dig_ones_val,
   output logic             ones_dec,
   output logic             tens_dec,
   output logic             ones_last,
   output logic [CNT_W-1:0] remaining,
   output logic             busy,
   output logic             timeout,
   output logic             warn
);

   state_t           state;
   logic             tick;
   logic             pre_en;
   logic             pre_clr;
   logic [CNT_W-1:0] preset_bin;
   logic [CNT_W-1:0] rem_dec;

   // Control inputs outrank the tick, so the prescaler never advances on a
   // cycle the FSM is about to leave RUN; that keeps the held count exact.
   assign pre_en     = (state == ST_RUN) && !abort && !start && !pause;
   assign pre_clr    = (state != ST_RUN) && (state != ST_PAUSED);
   assign preset_bin = CNT_W'(bcd_to_bin(dig_tens_val, dig_ones_val));
   assign rem_dec    = remaining - CNT_W'(1);
   assign busy       = (state == ST_LOAD) || (state == ST_RUN) || (state == ST_PAUSED);

   timer_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .clr  (pre_clr),
      .en   (pre_en),
      .tick (tick)
   );

   // Main FSM, shadow counter and registered strobes (abort > start > pause > tick).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         dig_load     <= 1'b0;
         dig_tens_val <= '0;
         dig_ones_val <= '0;
         ones_dec     <= 1'b0;
         tens_dec     <= 1'b0;
         timeout      <= 1'b0;
         ones_last    <= 1'b0;
         remaining    <= '0;
      end else begin
         dig_load <= 1'b0;
         ones_dec <= 1'b0;
         tens_dec <= 1'b0;
         timeout  <= 1'b0;
         if (abort) begin
            state <= ST_IDLE;
         end else if (start && state != ST_LOAD) begin
            // LOAD lasts one cycle, so a start there is dropped; this keeps
            // dig_load from ever stretching to two cycles.
            state        <= ST_LOAD;
            dig_load     <= 1'b1;
            dig_tens_val <= bcd_clamp(preset_tens);
            dig_ones_val <= bcd_clamp(preset_ones);
         end else begin
            case (state)
               ST_LOAD: begin
                  remaining <= preset_bin;
                  ones_last <= preset_bin < CNT_W'(10);
                  if (preset_bin == '0) begin
                     state   <= ST_EXPIRED;
                     timeout <= 1'b1;
                  end else begin
                     state   <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (pause) begin
                     state <= ST_PAUSED;
                  end else if (tick && remaining != '0) begin
                     ones_dec  <= 1'b1;
                     tens_dec  <= (remaining % CNT_W'(10)) == '0;
                     remaining <= rem_dec;
                     ones_last <= rem_dec < CNT_W'(10);
                     if (remaining == CNT_W'(1)) begin
                        state   <= ST_EXPIRED;
                        timeout <= 1'b1;
                     end
                  end
               end
               ST_PAUSED: begin
                  if (pause) state <= ST_RUN;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TIMER_WARN_EN
   // Low-time warning, one cycle behind remaining.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) warn <= 1'b0;
      else     warn <= ((state == ST_RUN) || (state == ST_PAUSED)) &&
                       (remaining != '0) && (remaining <= CNT_W'(WARN_SECS));
   end
`else
   logic warn_unused;
   assign warn_unused = |WARN_SECS;
   assign warn        = 1'b0;
`endif

endmodule

// File: doc/timer_tick_ctrl.md
Name: timer_tick_ctrl

Overview:
- Upstream control stage for the two-digit BCD countdown display chain (ones digit and tens digit counter cells).
- Divides the system clock into a seconds tick.
- Issues load and per-digit decrement strobes to the digit cells.
- Keeps a binary shadow of the remaining time, raises a one-cycle timeout when the count reaches zero, and runs start/pause/abort control from the game FSM.

Parameters:
- TICK_DIV, 50000000, clk cycles per tick; minimum 2.
- CNT_W, 7, shadow counter width; must hold 99.
- WARN_SECS, 5, warning threshold in seconds; used only when TIMER_WARN_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; loads the preset and begins the countdown.
- pause  in  1  single-cycle pulse; toggles RUN/PAUSED.
- abort  in  1  single-cycle pulse; returns to IDLE.
- preset_tens  in  4  BCD tens preset.
- preset_ones  in  4  BCD ones preset.
- dig_load  out  1  load strobe to both digit cells.
- dig_tens_val  out  4  clamped tens value presented with dig_load.
- dig_ones_val  out  4  clamped ones value presented with dig_load.
- ones_dec  out  1  decrement strobe, ones digit.
- tens_dec  out  1  decrement strobe, tens digit.
- ones_last  out  1  high when the tens part of the remaining time is 0; ones digit must stop at 0, not wrap.
- remaining  out  CNT_W  binary seconds remaining.
- busy  out  1  high in LOAD, RUN, PAUSED.
- timeout  out  1  one-cycle pulse on expiry.
- warn  out  1  see Optional Feature.

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler 0, remaining 0. Reset takes effect immediately and overrides any operation in progress.
- States: IDLE, LOAD, RUN, PAUSED, EXPIRED.
- Control priority, same cycle: abort > start > pause > tick.
- IDLE:
  - start -> LOAD.
  - dig_tens_val/dig_ones_val capture the clamped presets on the start cycle. Any nibble > 9 is clamped to 9.
- LOAD (exactly 1 cycle):
  - dig_load = 1.
  - remaining <= tens*10 + ones.
  - Prescaler cleared.
  - Next state RUN if the preset is nonzero. If the preset is 0, next state EXPIRED and timeout pulses on the cycle after LOAD.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. The tick fires on the cycle it equals TICK_DIV-1, then it wraps to 0.
  - On tick: ones_dec = 1 and remaining decrements by 1.
  - tens_dec = 1 on the same tick when (remaining mod 10) == 0 and remaining > 0.
  - On a tick with remaining == 1: remaining becomes 0, next state EXPIRED, timeout = 1 on that same cycle.
  - pause -> PAUSED. abort -> IDLE.
- PAUSED:
  - Prescaler and remaining hold. No strobes.
  - pause -> RUN; the prescaler resumes from its held value.
  - abort -> IDLE.
  - start -> LOAD (restart).
- EXPIRED:
  - Holds remaining = 0.
  - start -> LOAD. abort -> IDLE.
- start while in RUN -> LOAD (restart; prescaler cleared).
- pause in IDLE, LOAD or EXPIRED is ignored. abort in IDLE is a no-op.
- Strobe and pulse rules:
  - ones_dec, tens_dec, dig_load and timeout are registered single-cycle pulses, never high two cycles in a row.
  - Strobes are never asserted in the same cycle as dig_load.
- ones_last = (remaining < 10), registered alongside remaining.
- remaining saturates at 0; it never wraps below 0.

Optional Feature:
- Macro: TIMER_WARN_EN.
- Defined: warn = 1 while state is RUN or PAUSED and 0 < remaining <= WARN_SECS. warn is registered and updates the cycle after remaining changes.
- Undefined: warn is tied to 0 and no comparator logic is generated.

Decomposition:
- Shared package timer_pkg holds:
  - the state enumeration (IDLE, LOAD, RUN, PAUSED, EXPIRED);
  - BCD_MAX = 9;
  - the CNT_W default;
  - a BCD-to-binary clamp function, shared with the score display path.
- One sub-module: timer_prescaler, with inputs clk, rst, clr and en, and output tick; parameter TICK_DIV.
- The FSM and shadow counter stay in timer_tick_ctrl.

Test Plan:
1. TICK_DIV=4, preset 1/2 (12 s), start -> dig_load 1 cycle, then ones_dec every 4 cycles. tens_dec coincides with the tick taking remaining 10->9. Timeout on the tick taking 1->0, 48 cycles after RUN entry. ones_last rises when remaining drops to 9.
2. preset tens=0xC, ones=0xF, start -> dig_tens_val=9, dig_ones_val=9, remaining=99.
3. preset 0/0, start -> LOAD then EXPIRED, timeout pulses once, no decrement strobes.
4. RUN with remaining=7 and prescaler at 2, pause held 10 cycles then pause again -> no strobes while paused; next tick exactly 1 cycle after resume.
5. Same cycle abort+start+tick in RUN -> IDLE, no ones_dec, no dig_load, busy=0. Assert rst mid-RUN -> all outputs 0 immediately.
6. TIMER_WARN_EN defined, WARN_SECS=5, preset 0/8 -> warn rises the cycle after remaining reaches 5 and falls when EXPIRED is entered. Undefined -> warn stays 0 throughout.
